assoc_cache: RTL
================

# assoc_cache

Parametrised set-associative, write-through, no-write-allocate cache with multi-word lines and a line-refill state machine. It sits between the processor data port and the backing data memory. A request/ready handshake on the CPU side and a req/ack handshake on the memory side replace the fixed single-cycle access of the earlier direct-mapped cache.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width (multiple of 8)
- SETS, 16, number of sets (power of 2)
- WAYS, 2, associativity (1 or 2)
- WORDS_PER_LINE, 4, words per line (power of 2, ≥1)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cpu_req  in  1  request valid, held until cpu_ready
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_WIDTH  byte address (word aligned)
- cpu_wdata  in  DATA_WIDTH  write data
- cpu_be  in  DATA_WIDTH/8  byte enables for writes
- cpu_rdata  out  DATA_WIDTH  read data, valid with cpu_ready
- cpu_ready  out  1  one-cycle completion pulse
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write
- mem_addr  out  ADDR_WIDTH  memory word address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_be  out  DATA_WIDTH/8  memory byte enables
- mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion
- hit_count, miss_count  out  32  only with CACHE_STATS_EN

## Operation
- Address split: tag | index (log2 SETS) | word offset (log2 WORDS_PER_LINE) | byte offset (log2 DATA_WIDTH/8).
- Per way and set: valid bit, tag, line data. Per set: one LRU bit (unused when WAYS=1).
- FSM states: IDLE, REFILL, WRITE, RESPOND.
- IDLE: on cpu_req, compare tags of all ways at the index.
  - Read hit: go to RESPOND with the hit word; update LRU so the other way is the victim.
  - Read miss: pick a victim (the first invalid way, way 0 first; otherwise the LRU way), clear its valid bit, go to REFILL.
  - Write, hit or miss: go to WRITE.
- REFILL: issue WORDS_PER_LINE sequential reads to line_base, line_base+B, …, where B is the word size in bytes. One request is outstanding at a time. Each mem_ack stores mem_rdata into the victim line. After the last ack: set valid, write the tag, update LRU, go to RESPOND with the requested word.
- WRITE: drive mem_req=1, mem_we=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_be=cpu_be.
  - On a hit, merge the enabled bytes into the cached word in the same cycle as the request is issued.
  - A miss does not allocate.
  - On mem_ack go to RESPOND.
- RESPOND: assert cpu_ready for one cycle (cpu_rdata is valid for reads), then return to IDLE.
- Writes with cpu_be=0 are still forwarded to memory and leave cached data unchanged.
- mem_ack outside REFILL/WRITE is ignored. mem_* outputs are stable while mem_req=1.

## Timing
- Reset values: cpu_ready=0, cpu_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, counters=0, all valid bits=0, all LRU bits=0, state IDLE.
- Read hit: cpu_req sampled at edge N, cpu_ready high in cycle N+1.
- Read miss: mem_req rises in cycle N+1. mem_req stays high through each ack and the next read address is presented the cycle after an ack. cpu_ready comes one cycle after the final ack. With zero-wait memory (ack the cycle after req), total latency is 2·WORDS_PER_LINE+2.
- Write: mem_req in cycle N+1, cpu_ready the cycle after mem_ack.
- cpu_req is sampled only in IDLE. The CPU must drop it or present a new request in the cycle after cpu_ready.
- Reset in mid-operation aborts it: mem_req drops on the next edge, and the partially refilled line stays invalid.

## Configuration
- CACHE_STATS_EN defined:
  - hit_count and miss_count ports exist.
  - Each accepted request increments exactly one counter: on the IDLE-to-next-state edge, hit or miss.
  - Counters saturate at 32'hFFFF_FFFF and are cleared by reset.
- CACHE_STATS_EN undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- cache_pkg: FSM state enum, and width-derivation constants/functions (index, offset, byte-offset and tag widths) used by this block and its testbench.
- One sub-module, cache_way: one way's storage (valid, tag and data arrays), with a combinational hit output, word read, line-word write port and byte-enable merge. It is instantiated WAYS times.

## Test plan
- Reset, then read 0x0000_0040 with memory words 0x11,0x22,0x33,0x44 at 0x40–0x4C: 4 memory reads in order 0x40,0x44,0x48,0x4C; cpu_rdata=0x11; miss_count=1.
- Re-read 0x0000_0048: no mem_req, cpu_ready the next cycle with 0x33; hit_count=1.
- Write 0xAABBCCDD to 0x44 with be=4'b0011: memory write with be=0011; a subsequent read of 0x44 hits and returns 0x0000CCDD merged over 0x22 (i.e. 0x0000CCDD).
- WAYS=2, three lines mapping to index 0 (0x000, 0x100, 0x200), read 0x000, 0x100, 0x000, 0x200: 0x100 is evicted; reading 0x000 then hits and reading 0x100 misses.
- Assert reset during the second refill ack: mem_req=0 the next cycle; re-reading the same address causes a full 4-word refill.
- Write to an uncached address 0x300: one memory write, and a subsequent read of 0x300 misses (no allocate).

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: FSM state type and address-field width helpers for assoc_cache.
// Shared by the cache RTL and its testbench.
package cache_pkg;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE, RESPOND} state_t;

    // log2 of a power of two, 0 for n <= 1 (field absent from the address)
    function automatic int log2z(input int n);
        return (n > 1) ? $clog2(n) : 0;
    endfunction

    // storage index width; never zero so arrays and ports stay legal
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int tag_w(input int aw, input int dw, input int sets, input int wpl);
        return aw - log2z(dw / 8) - log2z(sets) - log2z(wpl);
    endfunction

endpackage

// File: rtl/cache_way.sv
// cache_way: one way of the cache - valid bits, tags and line data per set.
// Ports: idx/woff/tag select the looked-up word (hit, valid, rdata combinational);
//        inval/set_valid clear/set the set's valid bit (set_valid also writes tag);
//        fill_en writes fill_data to word fill_off; merge_en merges wdata under be
//        into word woff.
module cache_way #(
    parameter int DATA_WIDTH     = 32,
    parameter int SETS           = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int TAG_W          = 24,
    parameter int IW             = 4,
    parameter int OW             = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [IW-1:0]           idx,
    input  logic [OW-1:0]           woff,
    input  logic [TAG_W-1:0]        tag,
    output logic                    hit,
    output logic                    valid,
    output logic [DATA_WIDTH-1:0]   rdata,
    input  logic                    inval,
    input  logic                    set_valid,
    input  logic                    fill_en,
    input  logic [OW-1:0]           fill_off,
    input  logic [DATA_WIDTH-1:0]   fill_data,
    input  logic                    merge_en,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [DATA_WIDTH-1:0]   wdata
);

    logic [SETS-1:0]       v;
    logic [TAG_W-1:0]      tags [SETS];
    logic [DATA_WIDTH-1:0] data [SETS][WORDS_PER_LINE];
    logic [DATA_WIDTH-1:0] merged;

    always_comb begin
        valid  = v[idx];
        hit    = v[idx] && tags[idx] == tag;
        rdata  = data[idx][woff];
        merged = rdata;
        for (int i = 0; i < DATA_WIDTH / 8; i++)
            if (be[i]) merged[i*8 +: 8] = wdata[i*8 +: 8];
    end

    always_ff @(posedge clk) begin
        if (reset) v <= '0;
        else if (inval) v[idx] <= 1'b0;
        else if (set_valid) v[idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (set_valid) tags[idx] <= tag;
        if (fill_en) data[idx][fill_off] <= fill_data;
        if (merge_en) data[idx][woff] <= merged;
    end

endmodule

// File: rtl/assoc_cache.sv
// assoc_cache: set-associative write-through, no-write-allocate cache with line refill.
// Ports: cpu_* request/ready handshake from the processor; mem_* req/ack handshake
//        to backing memory; hit_count/miss_count only when CACHE_STATS_EN is defined.
// Macro CACHE_STATS_EN enables saturating hit/miss counters.
module assoc_cache
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int SETS           = 16,
    parameter int WAYS           = 2,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic [DATA_WIDTH-1:0]   cpu_wdata,
    input  logic [DATA_WIDTH/8-1:0] cpu_be,
    output logic [DATA_WIDTH-1:0]   cpu_rdata,
    output logic                    cpu_ready,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_ack
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]             hit_count,
    output logic [31:0]             miss_count
`endif
);

    localparam int BW     = DATA_WIDTH / 8;
    localparam int BOFF_W = log2z(BW);
    localparam int OFF_W  = log2z(WORDS_PER_LINE);
    localparam int IDX_W  = log2z(SETS);
    localparam int OW     = clog2_min1(WORDS_PER_LINE);
    localparam int IW     = clog2_min1(SETS);
    localparam int TW     = tag_w(ADDR_WIDTH, DATA_WIDTH, SETS, WORDS_PER_LINE);

    state_t                state, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, a, wa, line_base;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q, hit_word;
    logic [BW-1:0]         be_q;
    logic [OW-1:0]         woff, cnt_q;
    logic [IW-1:0]         idx;
    logic [TW-1:0]         tag;
    logic                  vic_q, victim, any_hit, accept, fill, last;
    logic [SETS-1:0]       lru_q;
    logic [WAYS-1:0]       hit_w, val_w;
    logic [DATA_WIDTH-1:0] rd_w [WAYS];

    // Lookup uses the live CPU address while idle, the captured one afterwards.
    always_comb begin
        a         = (state == IDLE) ? cpu_addr : addr_q;
        wa        = a >> BOFF_W;
        woff      = OW'(wa) & OW'(WORDS_PER_LINE - 1);
        idx       = IW'(wa >> OFF_W) & IW'(SETS - 1);
        tag       = TW'(a >> (BOFF_W + OFF_W + IDX_W));
        line_base = (a >> (BOFF_W + OFF_W)) << (BOFF_W + OFF_W);
        any_hit   = |hit_w;
        hit_word  = hit_w[0] ? rd_w[0] : rd_w[WAYS-1];
        // lru_q holds the index of the way to evict next
        victim    = (WAYS == 1) ? 1'b0 : !val_w[0] ? 1'b0 : !val_w[WAYS-1] ? 1'b1 : lru_q[idx];
        accept    = state == IDLE && cpu_req;
        fill      = state == REFILL && mem_ack;
        last      = cnt_q == OW'(WORDS_PER_LINE - 1);
    end

    assign cpu_ready = state == RESPOND;
    assign cpu_rdata = rdata_q;
    assign mem_req   = state == REFILL || state == WRITE;
    assign mem_we    = state == WRITE;
    assign mem_addr  = (state == REFILL) ? line_base + (ADDR_WIDTH'(cnt_q) << BOFF_W)
                     : (state == WRITE) ? addr_q : '0;
    assign mem_wdata = (state == WRITE) ? wdata_q : '0;
    assign mem_be    = (state == WRITE) ? be_q : '0;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        cache_way #(
            .DATA_WIDTH(DATA_WIDTH), .SETS(SETS), .WORDS_PER_LINE(WORDS_PER_LINE),
            .TAG_W(TW), .IW(IW), .OW(OW)
        ) u_way (
            .clk       (clk),
            .reset     (reset),
            .idx       (idx),
            .woff      (woff),
            .tag       (tag),
            .hit       (hit_w[w]),
            .valid     (val_w[w]),
            .rdata     (rd_w[w]),
            .inval     (accept && !cpu_we && !any_hit && victim == 1'(w)),
            .set_valid (fill && last && vic_q == 1'(w)),
            .fill_en   (fill && vic_q == 1'(w)),
            .fill_off  (cnt_q),
            .fill_data (mem_rdata),
            .merge_en  (accept && cpu_we && hit_w[w]),
            .be        (cpu_be),
            .wdata     (cpu_wdata)
        );
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (cpu_req) state_d = cpu_we ? WRITE : any_hit ? RESPOND : REFILL;
            REFILL:  if (mem_ack && last) state_d = RESPOND;
            WRITE:   if (mem_ack) state_d = RESPOND;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            vic_q   <= 1'b0;
            lru_q   <= '0;
        end else begin
            if (accept) begin
                addr_q  <= cpu_addr;
                wdata_q <= cpu_wdata;
                be_q    <= cpu_be;
                cnt_q   <= '0;
                vic_q   <= victim;
                if (!cpu_we && any_hit) begin
                    rdata_q    <= hit_word;
                    lru_q[idx] <= (WAYS == 2) && hit_w[0];
                end
            end
            if (fill) begin
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == woff) rdata_q <= mem_rdata;
                if (last) lru_q[idx] <= (WAYS == 2) && !vic_q;
            end
        end
    end

`ifdef CACHE_STATS_EN
    // A write counts as a hit when the line is present, even though it only merges.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (accept) begin
            if (any_hit && ~&hit_count) hit_count <= hit_count + 1'b1;
            if (!any_hit && ~&miss_count) miss_count <= miss_count + 1'b1;
        end
    end
`endif

endmodule
